change_dispenser: RTL

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser.sv | 112 +++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// Coin change dispenser: splits a multiple-of-5 kurus amount into 25/10/5 coin
// commands, one per hopper handshake, with every output driven from a register.
module change_dispenser (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] amount,
  input  logic       hopperReady,
  output logic       fiveKurusOut,
  output logic       tenKurusOut,
  output logic       twentyFiveKurusOut,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [5:0] coinCount
);

  typedef enum logic [1:0] {IDLE, SELECT, PULSE, DONE} state_t;

  state_t     state, state_nxt;
  logic [7:0] remaining, remaining_nxt;
  logic [5:0] count_nxt;
  logic       five_nxt, ten_nxt, twenty_five_nxt;
  logic       busy_nxt, done_nxt, error_nxt;
  logic       amount_ok;

  assign amount_ok = ((amount % 8'd5) == 8'd0);

  always_comb begin
    state_nxt       = state;
    remaining_nxt   = remaining;
    count_nxt       = coinCount;
    five_nxt        = 1'b0;
    ten_nxt         = 1'b0;
    twenty_five_nxt = 1'b0;
    error_nxt       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (!amount_ok) begin
            error_nxt = 1'b1;
          end else if (amount == 8'd0) begin
            count_nxt = 6'd0;
            state_nxt = DONE;
          end else begin
            remaining_nxt = amount;
            count_nxt     = 6'd0;
            state_nxt     = SELECT;
          end
        end
      end
      SELECT: begin
        // Greedy selection; remaining is always a nonzero multiple of 5 here.
        if (hopperReady) begin
          state_nxt = PULSE;
          count_nxt = coinCount + 6'd1;
          if (remaining >= 8'd25) begin
            twenty_five_nxt = 1'b1;
            remaining_nxt   = remaining - 8'd25;
          end else if (remaining >= 8'd10) begin
            ten_nxt       = 1'b1;
            remaining_nxt = remaining - 8'd10;
          end else if (remaining >= 8'd5) begin
            five_nxt      = 1'b1;
            remaining_nxt = remaining - 8'd5;
          end else begin
            count_nxt     = coinCount;
            remaining_nxt = 8'd0;
            state_nxt     = DONE;
          end
        end
      end
      PULSE: begin
        state_nxt = (remaining != 8'd0) ? SELECT : DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy_nxt = (state_nxt != IDLE);
  assign done_nxt = (state_nxt == DONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      remaining          <= 8'd0;
      coinCount          <= 6'd0;
      fiveKurusOut       <= 1'b0;
      tenKurusOut        <= 1'b0;
      twentyFiveKurusOut <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      error              <= 1'b0;
    end else begin
      state              <= state_nxt;
      remaining          <= remaining_nxt;
      coinCount          <= count_nxt;
      fiveKurusOut       <= five_nxt;
      tenKurusOut        <= ten_nxt;
      twentyFiveKurusOut <= twenty_five_nxt;
      busy               <= busy_nxt;
      done               <= done_nxt;
      error              <= error_nxt;
    end
  end

endmodule
